// File: rtl/digit_shuffler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// digit_shuffler
//   Builds a uniformly shuffled permutation of the digits 1..N from the
//   free-running LFSR word. It uses Fisher-Yates with rejection sampling: for
//   i = N-1 down to 1 a candidate index r is taken from rand_in. If r <= i,
//   perm[i] and perm[r] are swapped. If r > i, the candidate is rejected and a
//   new one is tried on the next cycle. After REJ_LIMIT consecutive rejects the
//   step is forced without a swap, which bounds the run time. The result is
//   held until the next request.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   rand_in    LFSR word that advances every clk
//   start      requests a new shuffle; it is sampled only in IDLE
//   busy       high while in INIT, SHUF or DONE
//   done       one-cycle pulse in the DONE cycle
//   valid      perm_out holds a finished shuffle
//   perm_out   digit at position k = perm_out[k*IDX_W +: IDX_W]
//   state_dbg  current FSM state (0 IDLE, 1 INIT, 2 SHUF, 3 DONE)
//
// Handshake: start is a request level sampled only in IDLE. A start seen
//   while busy is dropped (nothing is queued). done marks completion for one
//   cycle. valid stays high until the next accepted start, and perm_out is
//   meaningful only while valid=1.
// -----------------------------------------------------------------------------
module digit_shuffler #(
   parameter int N         = 9,
   parameter int IDX_W     = 4,
   parameter int RAND_LSB  = 0,
   parameter int REJ_LIMIT = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [15:0]        rand_in,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               valid,
   output logic [N*IDX_W-1:0] perm_out,
   output logic [1:0]         state_dbg
);

   localparam int REJ_W = $clog2(REJ_LIMIT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_INIT = 2'd1,
      S_SHUF = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   perm [N];
   logic [IDX_W-1:0]   idx_i;
   logic [REJ_W-1:0]   rej_cnt;

   logic [IDX_W-1:0]   cand_r;
   logic               accept;
   logic               force_step;
   logic               step;
   logic               last_step;
   logic [IDX_W-1:0]   perm_at_i;
   logic [IDX_W-1:0]   perm_at_r;

   // Only the candidate slice of the LFSR word is used.
   logic               unused_rand;
   assign unused_rand = ^rand_in;

   // Candidate index and the decision for the current SHUF cycle.
   assign cand_r     = rand_in[RAND_LSB +: IDX_W];
   assign accept     = (cand_r <= idx_i);
   assign force_step = !accept && (rej_cnt == REJ_W'(REJ_LIMIT));
   assign step       = accept || force_step;
   assign last_step  = step && (idx_i == IDX_W'(1));

   // Read ports for the two swap entries. They are built as explicit muxes so
   // that a rejected r (which can exceed N-1) never indexes past the array.
   always_comb begin
      perm_at_i = '0;
      perm_at_r = '0;
      for (int k = 0; k < N; k++) begin
         if (IDX_W'(k) == idx_i) perm_at_i = perm[k];
         if (IDX_W'(k) == cand_r) perm_at_r = perm[k];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_INIT;
         S_INIT:  state_nxt = S_SHUF;
         S_SHUF:  if (last_step) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs. They are decoded from the registered state.
   always_comb begin
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      state_dbg = state;
   end

   // Permutation datapath, index/reject counters and the valid flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N; k++) perm[k] <= IDX_W'(k + 1);
         idx_i   <= '0;
         rej_cnt <= '0;
         valid   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // Clear valid on the edge that enters INIT, so that the INIT
               // cycle already shows valid=0.
               if (start) valid <= 1'b0;
            end
            S_INIT: begin
               for (int k = 0; k < N; k++) perm[k] <= IDX_W'(k + 1);
               idx_i   <= IDX_W'(N - 1);
               rej_cnt <= '0;
            end
            S_SHUF: begin
               if (accept) begin
                  // Single-cycle swap. When r == i both writes carry the same
                  // value, so a self-swap leaves the entry unchanged.
                  for (int k = 0; k < N; k++) begin
                     if (IDX_W'(k) == idx_i)       perm[k] <= perm_at_r;
                     else if (IDX_W'(k) == cand_r) perm[k] <= perm_at_i;
                  end
                  idx_i   <= idx_i - IDX_W'(1);
                  rej_cnt <= '0;
               end else if (force_step) begin
                  idx_i   <= idx_i - IDX_W'(1);
                  rej_cnt <= '0;
               end else begin
                  rej_cnt <= rej_cnt + REJ_W'(1);
               end
               if (last_step) valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      perm_out = '0;
      for (int k = 0; k < N; k++) perm_out[k*IDX_W +: IDX_W] = perm[k];
   end

endmodule

// File: tb/tb_digit_shuffler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_digit_shuffler
//   Directed bench for digit_shuffler. Stimulus is a linear sequence of
//   directed steps, and every comparison is an immediate assertion.
//   Cycle numbering: cycle 0 ends at the edge that samples start, and cycle c
//   is the c-th clock period after that edge (cycle 1 = INIT).
// -----------------------------------------------------------------------------
module tb_digit_shuffler;

   localparam int N  = 9;
   localparam int W  = 4;
   localparam int PW = N * W;
   localparam int MAX_LAT = 2 + (N - 1) * 9;

   // Position k lives in nibble k.
   localparam logic [PW-1:0] IDENT   = 36'h987654321;
   localparam logic [PW-1:0] ROTATED = 36'h198765432; // [2,3,4,5,6,7,8,9,1]

   // ---- clock / reset ----
   logic          clk     = 1'b0;
   logic          rst     = 1'b0;
   logic [15:0]   rand_in = 16'h0000;
   logic          start   = 1'b0;
   logic          busy;
   logic          done;
   logic          valid;
   logic [PW-1:0] perm_out;
   logic [1:0]    state_dbg;

   always #5 clk = ~clk;

   digit_shuffler #(.N(N), .IDX_W(W), .RAND_LSB(0), .REJ_LIMIT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .rand_in   (rand_in),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .valid     (valid),
      .perm_out  (perm_out),
      .state_dbg (state_dbg)
   );

   int          checks = 0;
   int          errors = 0;
   logic [15:0] lfsr   = 16'hACE1;

   // ---- checker ----
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic is_perm(input logic [PW-1:0] p);
      logic [15:0] seen;
      logic [W-1:0] d;
      seen = '0;
      for (int k = 0; k < N; k++) begin
         d = p[k*W +: W];
         if (d < 4'd1 || d > 4'd9) return 1'b0;
         seen[d] = 1'b1;
      end
      return (seen == 16'h03FE);
   endfunction

   // ---- driver ----
   // mode 0: rand_in is held as set by the caller
   // mode 1: rand_in makes r == i in every SHUF cycle
   // mode 2: rand_in follows a 16-bit Galois LFSR that advances every cycle
   // The task returns at the negedge of the done cycle. lat is 0 if the
   // budget runs out first.
   task automatic run_shuffle(input int mode, input int budget, output int lat);
      lat = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         if (mode == 1) rand_in = (c >= 2 && c <= 9) ? 16'(10 - c) : 16'h0000;
         else if (mode == 2) begin
            lfsr    = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            rand_in = lfsr;
         end
         @(negedge clk);
         if (c == 1) begin
            check("init_busy", busy, 1);
            check("init_valid_low", valid, 0);
         end
         if (done) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   // ---- directed sequence ----
   initial begin
      int          lat;
      int          dn;
      int          first_done;
      int          second_done;
      logic [PW-1:0] prev;

      // Reset
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", valid, 0);
      check("rst_perm", perm_out, IDENT);
      rst = 1'b1;

      // T1: r = 0 every cycle rotates the digits
      rand_in = 16'h0000;
      run_shuffle(0, 100, lat);
      check("t1_latency", lat, 10);
      check("t1_perm", perm_out, ROTATED);
      check("t1_valid_at_done", valid, 1);
      check("t1_busy_at_done", busy, 1);
      @(negedge clk);
      check("t1_done_pulse_end", done, 0);
      check("t1_idle_busy", busy, 0);
      check("t1_valid_hold", valid, 1);
      check("t1_perm_hold", perm_out, ROTATED);

      // T2: r = 15 is always rejected, so every step is forced
      rand_in = 16'h000F;
      run_shuffle(0, 100, lat);
      check("t2_latency", lat, MAX_LAT);
      check("t2_perm", perm_out, IDENT);
      check("t2_valid", valid, 1);

      // T3: r == i every SHUF cycle gives only self-swaps
      run_shuffle(1, 100, lat);
      check("t3_latency", lat, 10);
      check("t3_perm", perm_out, IDENT);

      // T4: live LFSR, 50 back-to-back shuffles
      prev = perm_out;
      for (int n = 0; n < 50; n++) begin
         run_shuffle(2, 100, lat);
         check("t4_latency_in_range", (lat >= 10 && lat <= MAX_LAT), 1);
         check("t4_is_perm", is_perm(perm_out), 1);
         check("t4_differs_prev", (perm_out !== prev), 1);
         prev = perm_out;
      end

      // T5: asynchronous reset in the middle of SHUF
      rand_in = 16'h0000;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("t5_busy", busy, 0);
      check("t5_valid", valid, 0);
      check("t5_done", done, 0);
      check("t5_perm", perm_out, IDENT);
      @(posedge clk); #1 rst = 1'b1;
      run_shuffle(0, 100, lat);
      check("t5_after_latency", lat, 10);
      check("t5_after_perm", perm_out, ROTATED);

      // T6: start during SHUF (cycle 4) and during DONE (cycle 10) is ignored,
      // and start in the following IDLE cycle (cycle 11) is accepted.
      rand_in     = 16'h0000;
      dn          = 0;
      first_done  = 0;
      second_done = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         start = (c == 4 || c == 10 || c == 11);
         @(negedge clk);
         if (done) begin
            dn++;
            if (first_done == 0) first_done = c;
            else second_done = c;
         end
         if (c == 11) check("t6_idle_after_done", busy, 0);
         if (c == 12) begin
            check("t6_restart_busy", busy, 1);
            check("t6_restart_valid_low", valid, 0);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("t6_done_count", dn, 2);
      check("t6_first_done", first_done, 10);
      check("t6_second_done", second_done, 21);
      check("t6_perm", perm_out, ROTATED);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
